// File: rtl/lane_deskew_pkg.sv
// Shared types and default sizing for the lane deskew block.
package lane_deskew_pkg;

  // Default geometry: 20 PCS lanes of 66b coded blocks.
  localparam int DEF_N_LANES    = 20;
  localparam int DEF_NB_DATA    = 66;
  // Largest tolerated distance, in valid cycles, between the first and
  // the last start_of_lane of one alignment period.
  localparam int DEF_MAX_SKEW   = 32;
  // Must exceed DEF_MAX_SKEW+1 so the earliest lane can never fill up.
  localparam int DEF_FIFO_DEPTH = 64;

  // Deskew controller states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    ALIGNED = 2'd2
  } state_e;

endpackage

// File: rtl/lane_deskew_fifo.sv
// Per-lane deskew FIFO: synchronous write/read, one-cycle pointer flush,
// occupancy count and an overflow flag for writes into a full FIFO.
module deskew_fifo
  import lane_deskew_pkg::*;
#(
  parameter  int WIDTH  = DEF_NB_DATA,
  parameter  int DEPTH  = DEF_FIFO_DEPTH,
  localparam int NB_PTR = $clog2(DEPTH)
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_flush,
  input  logic              i_wr,
  input  logic              i_rd,
  input  logic [WIDTH-1:0]  i_wdata,
  output logic [WIDTH-1:0]  o_rdata,
  output logic [NB_PTR:0]   o_count,
  output logic              o_overflow
);

  localparam logic [NB_PTR:0] FULL_CNT = DEPTH[NB_PTR:0];

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [NB_PTR-1:0] wr_ptr_q, rd_ptr_q;
  logic [NB_PTR:0]   count_q, count_d;
  logic              full, empty, do_wr, do_rd;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign o_rdata = mem_q[rd_ptr_q];
  assign o_count = count_q;

  // Qualify requests: never read empty, only write full when a read frees a slot.
  always_comb begin
    do_rd      = i_rd & ~empty;
    do_wr      = i_wr & (~full | do_rd);
    o_overflow = i_wr & full & ~do_rd & ~i_flush;
    count_d    = count_q;
    unique case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers and count; flush rewinds them in one cycle, storage is untouched.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (i_flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage array, no reset needed: only written slots are ever read.
  always_ff @(posedge i_clock) begin
    if (do_wr && !i_flush) mem_q[wr_ptr_q] <= i_wdata;
  end

endmodule

// File: rtl/lane_deskew.sv
// Lane deskew: buffers each lane from its alignment-marker block onward and
// releases all lanes together once the last lane has seen its marker, so
// every AM block lands on the same output word.
// Build option DESKEW_REALIGN_CHECK_EN: FIFO entries also carry the
// start_of_lane flag, and a read whose lanes disagree on that flag reports
// an error and restarts collection.
module lane_deskew
  import lane_deskew_pkg::*;
#(
  parameter int N_LANES     = DEF_N_LANES,
  parameter int NB_DATA     = DEF_NB_DATA,
  parameter int MAX_SKEW    = DEF_MAX_SKEW,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int NB_DATA_BUS = N_LANES*NB_DATA
) (
  input  logic                          i_clock,
  input  logic                          i_reset_n,
  input  logic                          i_valid,
  input  logic [NB_DATA_BUS-1:0]        i_data,
  input  logic [N_LANES-1:0]            i_am_lock,
  input  logic [N_LANES-1:0]            i_start_of_lane,
  output logic [NB_DATA_BUS-1:0]        o_data,
  output logic                          o_valid,
  output logic                          o_deskew_done,
  output logic                          o_deskew_error,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

  localparam int NB_PTR  = $clog2(FIFO_DEPTH);
  localparam int NB_SKEW = $clog2(MAX_SKEW+1);
`ifdef DESKEW_REALIGN_CHECK_EN
  localparam int NB_ENT  = NB_DATA + 1;
`else
  localparam int NB_ENT  = NB_DATA;
`endif

  state_e                        state_q;
  logic [N_LANES-1:0]            started_q, started_nxt, sol_lane;
  logic [N_LANES-1:0]            wr_en, ovf, nempty;
  logic [N_LANES-1:0][NB_PTR:0]  cnt;
  logic [NB_SKEW-1:0]            skew_q;
  logic                          counting_q;
  logic                          lock_all, all_nxt, any_sol;
  logic                          rd_en, flush, skew_hit, realign_err;
  logic [NB_DATA_BUS-1:0]        head_bus, data_q;
  logic                          valid_q, done_q, err_q;
`ifdef DESKEW_REALIGN_CHECK_EN
  logic [N_LANES-1:0]            head_sol;
`endif

  // Internal lane vectors are indexed by lane number (lane 0 = bit 0);
  // the external buses carry lane 0 in the MSBs.
  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    logic [NB_ENT-1:0]  wdata, rdata;
    logic [NB_DATA-1:0] blk;

    assign sol_lane[i] = i_start_of_lane[N_LANES-1-i];
    assign blk         = i_data[NB_DATA_BUS-1-i*NB_DATA -: NB_DATA];
`ifdef DESKEW_REALIGN_CHECK_EN
    assign wdata       = {sol_lane[i], blk};
    assign head_sol[i] = rdata[NB_DATA];
`else
    assign wdata       = blk;
`endif
    assign head_bus[NB_DATA_BUS-1-i*NB_DATA -: NB_DATA] = rdata[NB_DATA-1:0];
    assign nempty[i]   = |cnt[i];

    deskew_fifo #(
      .WIDTH (NB_ENT),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .i_clock    (i_clock),
      .i_reset_n  (i_reset_n),
      .i_flush    (flush),
      .i_wr       (wr_en[i]),
      .i_rd       (rd_en),
      .i_wdata    (wdata),
      .o_rdata    (rdata),
      .o_count    (cnt[i]),
      .o_overflow (ovf[i])
    );
  end

  assign lock_all    = &i_am_lock;
  assign started_nxt = started_q | sol_lane;
  assign all_nxt     = &started_nxt;
  assign any_sol     = |sol_lane;

  // FIFO control: flush outside lock, gated writes while collecting,
  // lock-step write+read once aligned.
  always_comb begin
    wr_en       = '0;
    rd_en       = 1'b0;
    flush       = 1'b0;
    skew_hit    = 1'b0;
    realign_err = 1'b0;
    unique case (state_q)
      IDLE: flush = 1'b1;
      COLLECT: begin
        if (!lock_all) begin
          flush = 1'b1;
        end else if (i_valid) begin
          // The AM block itself is written, so it is always the first entry.
          wr_en    = started_nxt;
          skew_hit = counting_q && !all_nxt && (int'(skew_q) + 1 >= MAX_SKEW);
          flush    = skew_hit;
        end
      end
      ALIGNED: begin
        if (!lock_all) begin
          flush = 1'b1;
        end else if (i_valid) begin
`ifdef DESKEW_REALIGN_CHECK_EN
          // All lanes must pop their next AM block on the same read.
          realign_err = (&nempty) && (|head_sol) && !(&head_sol);
`endif
          flush = realign_err;
          wr_en = '1;
          rd_en = (&nempty) && !realign_err;
        end
      end
      default: flush = 1'b1;
    endcase
  end

  // Controller state, skew counter and registered outputs.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= IDLE;
      started_q  <= '0;
      counting_q <= 1'b0;
      skew_q     <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      valid_q <= rd_en;
      err_q   <= skew_hit | realign_err | (|ovf);
      if (rd_en) data_q <= head_bus;
      unique case (state_q)
        IDLE: begin
          started_q  <= '0;
          counting_q <= 1'b0;
          skew_q     <= '0;
          done_q     <= 1'b0;
          if (i_valid && lock_all) state_q <= COLLECT;
        end
        COLLECT: begin
          if (!lock_all) begin
            state_q    <= IDLE;
            started_q  <= '0;
            counting_q <= 1'b0;
          end else if (i_valid) begin
            if (skew_hit) begin
              // Skew budget exhausted: drop everything and wait for a new period.
              started_q  <= '0;
              counting_q <= 1'b0;
              skew_q     <= '0;
            end else if (all_nxt) begin
              state_q    <= ALIGNED;
              done_q     <= 1'b1;
              started_q  <= '0;
              counting_q <= 1'b0;
            end else begin
              started_q <= started_nxt;
              if (counting_q)   skew_q <= skew_q + 1'b1;
              else if (any_sol) begin
                counting_q <= 1'b1;
                skew_q     <= '0;
              end
            end
          end
        end
        ALIGNED: begin
          if (!lock_all) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end else if (realign_err) begin
            state_q <= COLLECT;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_data         = data_q;
  assign o_valid        = valid_q;
  assign o_deskew_done  = done_q;
  assign o_deskew_error = err_q;
  assign o_fifo_level   = cnt[0];

endmodule

// File: tb/tb_lane_deskew.sv
// Scoreboard bench for lane_deskew: each lane carries a tagged block stream
// that restarts at its start_of_lane; every word that becomes complete
// across all lanes is queued and compared when o_valid shows up.
module tb_lane_deskew;
  localparam int N   = 20;
  localparam int NB  = 66;
  localparam int BUS = N*NB;

  logic             i_clock = 1'b0;
  logic             i_reset_n;
  logic             i_valid;
  logic [BUS-1:0]   i_data;
  logic [N-1:0]     i_am_lock;
  logic [N-1:0]     i_start_of_lane;
  logic [BUS-1:0]   o_data;
  logic             o_valid;
  logic             o_deskew_done;
  logic             o_deskew_error;
  logic [6:0]       o_fifo_level;

  int               n_vec = 0;
  int               n_err = 0;
  int               pos [N];
  logic [BUS-1:0]   sb_q [$];

  lane_deskew dut (
    .i_clock         (i_clock),
    .i_reset_n       (i_reset_n),
    .i_valid         (i_valid),
    .i_data          (i_data),
    .i_am_lock       (i_am_lock),
    .i_start_of_lane (i_start_of_lane),
    .o_data          (o_data),
    .o_valid         (o_valid),
    .o_deskew_done   (o_deskew_done),
    .o_deskew_error  (o_deskew_error),
    .o_fifo_level    (o_fifo_level)
  );

  always #5 i_clock = ~i_clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // Block p of lane k (p=0 is the AM block).
  function automatic logic [NB-1:0] blk(input int k, input int p);
    logic [31:0] mix;
    mix = 32'(k*7919 + p*104729) ^ 32'h5A5AA5A5;
    return {2'b10, k[7:0], p[23:0], mix};
  endfunction

  // One clock: drive lanes (sol indexed by lane number), queue any word that
  // is now complete on every lane, then sample and score o_data.
  task automatic drive_cycle(input logic v, input logic [N-1:0] sol);
    logic [95:0]    rnd;
    logic [BUS-1:0] w, exp;
    int             mn;
    i_valid = v;
    for (int k = 0; k < N; k++) begin
      if (v) begin
        if (sol[k])          pos[k] = 0;
        else if (pos[k] >= 0) pos[k]++;
      end
      i_start_of_lane[N-1-k] = v & sol[k];
      if (pos[k] >= 0) i_data[BUS-1-k*NB -: NB] = blk(k, pos[k]);
      else begin
        rnd = {$urandom(), $urandom(), $urandom()};
        i_data[BUS-1-k*NB -: NB] = rnd[NB-1:0];
      end
    end
    if (v) begin
      mn = pos[0];
      for (int k = 1; k < N; k++) if (pos[k] < mn) mn = pos[k];
      if (mn >= 0) begin
        for (int k = 0; k < N; k++) w[BUS-1-k*NB -: NB] = blk(k, mn);
        sb_q.push_back(w);
      end
    end
    @(posedge i_clock);
    #1;
    if (o_valid === 1'b1) begin
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard: o_valid=1 with no expected word, got lane0 %h", o_data[BUS-1 -: NB]);
      end else begin
        exp = sb_q.pop_front();
        if (o_data !== exp) begin
          n_err++;
          for (int k = 0; k < N; k++)
            if (o_data[BUS-1-k*NB -: NB] !== exp[BUS-1-k*NB -: NB]) begin
              $display("FAIL scoreboard lane %0d: got %h expected %h", k,
                       o_data[BUS-1-k*NB -: NB], exp[BUS-1-k*NB -: NB]);
              break;
            end
        end
      end
    end
  endtask

  // Drop lock for a cycle, then relock: leaves the DUT in COLLECT, empty.
  task automatic restart();
    for (int k = 0; k < N; k++) pos[k] = -1;
    sb_q.delete();
    i_am_lock = '0;
    drive_cycle(1'b1, '0);
    i_am_lock = '1;
    drive_cycle(1'b1, '0);
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0; i_valid = 1'b0; i_data = '0;
    i_am_lock = '0; i_start_of_lane = '0;
    for (int k = 0; k < N; k++) pos[k] = -1;
    repeat (2) @(posedge i_clock);
    #1;
    n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset o_valid: got %b expected 0", o_valid); end
    n_vec++; if (o_deskew_done !== 1'b0) begin n_err++; $display("FAIL reset done: got %b expected 0", o_deskew_done); end
    n_vec++; if (o_deskew_error !== 1'b0) begin n_err++; $display("FAIL reset error: got %b expected 0", o_deskew_error); end
    n_vec++; if (o_fifo_level !== 7'd0) begin n_err++; $display("FAIL reset level: got %0d expected 0", o_fifo_level); end
    n_vec++; if (o_data !== '0) begin n_err++; $display("FAIL reset o_data: lane0 got %h expected 0", o_data[BUS-1 -: NB]); end
    i_reset_n = 1'b1;
  endtask

  task automatic test_zero_skew();
    restart();
    drive_cycle(1'b1, '1);
    n_vec++; if (o_deskew_done !== 1'b1) begin n_err++; $display("FAIL zero_skew done: got %b expected 1", o_deskew_done); end
    n_vec++; if (o_fifo_level !== 7'd1) begin n_err++; $display("FAIL zero_skew level: got %0d expected 1", o_fifo_level); end
    n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL zero_skew early valid: got %b expected 0", o_valid); end
    drive_cycle(1'b1, '0);
    n_vec++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL zero_skew valid rise: got %b expected 1", o_valid); end
    repeat (4) drive_cycle(1'b1, '0);
    n_vec++; if (o_fifo_level !== 7'd1) begin n_err++; $display("FAIL zero_skew steady level: got %0d expected 1", o_fifo_level); end
    n_vec++; if (sb_q.size() != 1) begin n_err++; $display("FAIL zero_skew pending: got %0d expected 1", sb_q.size()); end
  endtask

  task automatic test_staggered();
    logic [N-1:0] m;
    restart();
    for (int t = 0; t < N; t++) begin
      m = '0; m[t] = 1'b1;
      drive_cycle(1'b1, m);
      if (t == N-2) begin
        n_vec++; if (o_deskew_done !== 1'b0) begin n_err++; $display("FAIL staggered early done: got %b expected 0", o_deskew_done); end
      end
    end
    n_vec++; if (o_deskew_done !== 1'b1) begin n_err++; $display("FAIL staggered done: got %b expected 1", o_deskew_done); end
    n_vec++; if (o_fifo_level !== 7'd20) begin n_err++; $display("FAIL staggered level: got %0d expected 20", o_fifo_level); end
    repeat (5) drive_cycle(1'b1, '0);
    n_vec++; if (o_fifo_level !== 7'd20) begin n_err++; $display("FAIL staggered steady level: got %0d expected 20", o_fifo_level); end
    n_vec++; if (sb_q.size() != 1) begin n_err++; $display("FAIL staggered pending: got %0d expected 1", sb_q.size()); end
  endtask

  task automatic test_overflow();
    restart();
    drive_cycle(1'b1, 20'hFFFDF);   // every lane except 5
    for (int k = 1; k <= 33; k++) begin
      drive_cycle(1'b1, '0);
      n_vec++;
      if (o_deskew_error !== (k == 32)) begin
        n_err++; $display("FAIL overflow error at +%0d: got %b expected %b", k, o_deskew_error, (k == 32));
      end
      if (k == 32) for (int j = 0; j < N; j++) pos[j] = -1;
    end
    n_vec++; if (o_fifo_level !== 7'd0) begin n_err++; $display("FAIL overflow flushed level: got %0d expected 0", o_fifo_level); end
    n_vec++; if (o_deskew_done !== 1'b0) begin n_err++; $display("FAIL overflow done: got %b expected 0", o_deskew_done); end
    drive_cycle(1'b1, '1);
    n_vec++; if (o_deskew_done !== 1'b1) begin n_err++; $display("FAIL overflow realign done: got %b expected 1", o_deskew_done); end
    n_vec++; if (o_fifo_level !== 7'd1) begin n_err++; $display("FAIL overflow realign level: got %0d expected 1", o_fifo_level); end
    repeat (3) drive_cycle(1'b1, '0);
    n_vec++; if (sb_q.size() != 1) begin n_err++; $display("FAIL overflow pending: got %0d expected 1", sb_q.size()); end
  endtask

  task automatic test_lock_loss();
    i_am_lock[N-1-3] = 1'b0;
    drive_cycle(1'b1, '0);
    n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL lock_loss valid: got %b expected 0", o_valid); end
    n_vec++; if (o_deskew_done !== 1'b0) begin n_err++; $display("FAIL lock_loss done: got %b expected 0", o_deskew_done); end
    sb_q.delete();
    for (int k = 0; k < N; k++) pos[k] = -1;
    i_am_lock = '1;
    drive_cycle(1'b1, '0);
    drive_cycle(1'b1, 20'h003FF);
    drive_cycle(1'b1, 20'hFFC00);
    n_vec++; if (o_deskew_done !== 1'b1) begin n_err++; $display("FAIL lock_loss realign done: got %b expected 1", o_deskew_done); end
    n_vec++; if (o_fifo_level !== 7'd2) begin n_err++; $display("FAIL lock_loss level: got %0d expected 2", o_fifo_level); end
    repeat (4) drive_cycle(1'b1, '0);
    n_vec++; if (sb_q.size() != 1) begin n_err++; $display("FAIL lock_loss pending: got %0d expected 1", sb_q.size()); end
  endtask

  task automatic test_valid_gaps_reset();
    restart();
    drive_cycle(1'b1, 20'h003FF);
    drive_cycle(1'b0, '0); drive_cycle(1'b1, '0);
    drive_cycle(1'b0, '0); drive_cycle(1'b1, '0);
    n_vec++; if (o_deskew_done !== 1'b0) begin n_err++; $display("FAIL gaps early done: got %b expected 0", o_deskew_done); end
    drive_cycle(1'b0, '0);
    drive_cycle(1'b1, 20'hFFC00);
    n_vec++; if (o_deskew_done !== 1'b1) begin n_err++; $display("FAIL gaps done: got %b expected 1", o_deskew_done); end
    n_vec++; if (o_fifo_level !== 7'd4) begin n_err++; $display("FAIL gaps level: got %0d expected 4", o_fifo_level); end
    for (int i = 0; i < 8; i++) drive_cycle(logic'(i % 2), '0);
    n_vec++; if (o_fifo_level !== 7'd4) begin n_err++; $display("FAIL gaps steady level: got %0d expected 4", o_fifo_level); end
    n_vec++; if (sb_q.size() != 1) begin n_err++; $display("FAIL gaps pending: got %0d expected 1", sb_q.size()); end
    // Asynchronous reset between clock edges while aligned.
    #3 i_reset_n = 1'b0;
    #1;
    n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL async reset valid: got %b expected 0", o_valid); end
    n_vec++; if (o_deskew_done !== 1'b0) begin n_err++; $display("FAIL async reset done: got %b expected 0", o_deskew_done); end
    n_vec++; if (o_fifo_level !== 7'd0) begin n_err++; $display("FAIL async reset level: got %0d expected 0", o_fifo_level); end
    n_vec++; if (o_data !== '0) begin n_err++; $display("FAIL async reset o_data: lane0 got %h expected 0", o_data[BUS-1 -: NB]); end
    #3 i_reset_n = 1'b1;
    sb_q.delete();
    for (int k = 0; k < N; k++) pos[k] = -1;
  endtask

`ifdef DESKEW_REALIGN_CHECK_EN
  task automatic test_realign();
    restart();
    drive_cycle(1'b1, '1);
    repeat (3) drive_cycle(1'b1, '0);
    drive_cycle(1'b1, 20'hFFF7F);   // next AM period, lane 7 late
    n_vec++; if (o_deskew_error !== 1'b0) begin n_err++; $display("FAIL realign early error: got %b expected 0", o_deskew_error); end
    sb_q.delete();
    drive_cycle(1'b1, 20'h00080);
    n_vec++; if (o_deskew_error !== 1'b1) begin n_err++; $display("FAIL realign error: got %b expected 1", o_deskew_error); end
    n_vec++; if (o_deskew_done !== 1'b0) begin n_err++; $display("FAIL realign done: got %b expected 0", o_deskew_done); end
    n_vec++; if (o_fifo_level !== 7'd0) begin n_err++; $display("FAIL realign level: got %0d expected 0", o_fifo_level); end
    sb_q.delete();
    for (int k = 0; k < N; k++) pos[k] = -1;
    drive_cycle(1'b1, '0);
    n_vec++; if (o_deskew_error !== 1'b0) begin n_err++; $display("FAIL realign pulse width: got %b expected 0", o_deskew_error); end
    drive_cycle(1'b1, '1);
    n_vec++; if (o_deskew_done !== 1'b1) begin n_err++; $display("FAIL realign recover: got %b expected 1", o_deskew_done); end
  endtask
`endif

  initial begin
    test_reset();
    test_zero_skew();
    test_staggered();
    test_overflow();
    test_lock_loss();
    test_valid_gaps_reset();
`ifdef DESKEW_REALIGN_CHECK_EN
    test_realign();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
